// File: rtl/vga_pkg.sv
// vga_pkg: shared display geometry and tile-map sizing for the tile-map arbiter.
package vga_pkg;
    localparam int HPIXELS    = 640;
    localparam int VLINES     = 480;
    localparam int TILE_SHIFT = 4;
    localparam int MAP_COLS   = 40;
    localparam int MAP_ROWS   = 30;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 4;
    typedef logic [DATA_W-1:0] tile_code_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter; a requester granted last cycle is masked for one cycle.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);
    logic       ptr_q;
    logic [1:0] last_q;
    logic [1:0] elig;
    assign elig  = req_i & ~last_q;
    assign gnt_o = !en_i ? 2'b00 : (&elig) ? (ptr_q ? 2'b10 : 2'b01) : elig;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q  <= 1'b0;
            last_q <= 2'b00;
        end else begin
            last_q <= gnt_o;
            if (|gnt_o) ptr_q <= gnt_o[0];
        end
    end
endmodule

// File: rtl/vga_tilemap_arbiter.sv
// vga_tilemap_arbiter: tile-map RAM port owner; display reads in active video,
// round-robin writes during blanking, plus a start-of-vblank tick.
module vga_tilemap_arbiter #(
    parameter int TILE_SHIFT = vga_pkg::TILE_SHIFT,
    parameter int MAP_COLS   = vga_pkg::MAP_COLS,
    parameter int MAP_ROWS   = vga_pkg::MAP_ROWS,
    parameter int ADDR_W     = vga_pkg::ADDR_W,
    parameter int DATA_W     = vga_pkg::DATA_W,
    parameter int HPIXELS    = vga_pkg::HPIXELS,
    parameter int VLINES     = vga_pkg::VLINES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pix_valid,
    input  logic [9:0]            i_col,
    input  logic [9:0]            i_row,
    input  logic [1:0]            i_req,
    input  logic [2*ADDR_W-1:0]   i_wr_addr,
    input  logic [2*DATA_W-1:0]   i_wr_data,
    output logic [1:0]            o_gnt,
    output logic                  o_wr_err,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic                  o_ram_we,
    output logic [DATA_W-1:0]     o_ram_wdata,
    output logic                  o_disp_valid,
    output logic                  o_frame_tick
);
    logic [1:0]        pick;
    logic [ADDR_W-1:0] r, c, disp_addr, addr_sel;
    logic [DATA_W-1:0] data_sel;
    logic              oob;
    logic [1:0]        gnt_q, gnt_d;
    logic              err_q, err_d, we_q, we_d, dv1_q, dv_q, tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (i_req),
        .en_i  (!i_pix_valid),
        .gnt_o (pick)
    );

    // Row stride of 40 tiles as (r*32 + r*8); the largest tile index is 1199.
    assign r         = ADDR_W'(i_row >> TILE_SHIFT);
    assign c         = ADDR_W'(i_col >> TILE_SHIFT);
    assign disp_addr = (r << 5) + (r << 3) + c;
    assign addr_sel  = pick[1] ? i_wr_addr[ADDR_W +: ADDR_W] : i_wr_addr[0 +: ADDR_W];
    assign data_sel  = pick[1] ? i_wr_data[DATA_W +: DATA_W] : i_wr_data[0 +: DATA_W];
    assign oob       = addr_sel >= ADDR_W'(MAP_COLS * MAP_ROWS);

    always_comb begin
        gnt_d   = pick;
        addr_d  = i_pix_valid ? disp_addr : (|pick) ? addr_sel : addr_q;
        wdata_d = (|pick) ? data_sel : wdata_q;
        we_d    = (|pick) && !oob;
        err_d   = (|pick) && oob;
        tick_d  = (i_row == 10'(VLINES)) && (i_col == 10'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            dv1_q   <= 1'b0;
            dv_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            dv1_q   <= i_pix_valid;
            dv_q    <= dv1_q;
            tick_q  <= tick_d;
        end
    end

    assign o_gnt        = gnt_q;
    assign o_wr_err     = err_q;
    assign o_ram_addr   = addr_q;
    assign o_ram_we     = we_q;
    assign o_ram_wdata  = wdata_q;
    assign o_disp_valid = dv_q;
    assign o_frame_tick = tick_q;
endmodule

// File: tb/tb_vga_tilemap_arbiter.sv
// tb_vga_tilemap_arbiter: directed and randomized checks against a cycle-level reference model.
module tb_vga_tilemap_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pv;
    logic [9:0]  col, row;
    logic [1:0]  req;
    logic [10:0] wa [2];
    logic [3:0]  wd [2];
    logic [1:0]  o_gnt;
    logic        o_wr_err, o_ram_we, o_disp_valid, o_frame_tick;
    logic [10:0] o_ram_addr;
    logic [3:0]  o_ram_wdata;
    int total = 0, bad = 0;
    int m_prio = 0, m_prev = -1, m_addr = 0, m_wdata = 0;
    bit m_pv_prev = 0;
    bit done [2];
    int tick_cnt;

    always #5 clk = ~clk;

    vga_tilemap_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_pix_valid  (pv),
        .i_col        (col),
        .i_row        (row),
        .i_req        (req),
        .i_wr_addr    ({wa[1], wa[0]}),
        .i_wr_data    ({wd[1], wd[0]}),
        .o_gnt        (o_gnt),
        .o_wr_err     (o_wr_err),
        .o_ram_addr   (o_ram_addr),
        .o_ram_we     (o_ram_we),
        .o_ram_wdata  (o_ram_wdata),
        .o_disp_valid (o_disp_valid),
        .o_frame_tick (o_frame_tick)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Predict the outputs of the coming edge from the current inputs, then compare.
    task automatic step();
        int win = -1;
        int e_gnt, e_we = 0, e_err = 0, e_dv, e_tick;
        bit el0 = req[0] && m_prev != 0;
        bit el1 = req[1] && m_prev != 1;
        if (!pv) win = (el0 && el1) ? m_prio : el0 ? 0 : el1 ? 1 : -1;
        e_gnt = (win < 0) ? 0 : (1 << win);
        if (pv) m_addr = (int'(row) / 16) * 40 + int'(col) / 16;
        else if (win >= 0) begin
            m_addr  = int'(wa[win]);
            m_wdata = int'(wd[win]);
            e_err   = (m_addr >= 1200);
            e_we    = !e_err;
        end
        e_dv   = m_pv_prev;
        e_tick = (row == 480 && col == 0);
        m_pv_prev = pv;
        m_prev    = win;
        if (win >= 0) m_prio = 1 - win;
        @(posedge clk);
        #1;
        check("gnt", o_gnt, e_gnt);
        check("we", o_ram_we, e_we);
        check("err", o_wr_err, e_err);
        check("addr", o_ram_addr, m_addr);
        check("wdata", o_ram_wdata, m_wdata);
        check("disp_valid", o_disp_valid, e_dv);
        check("frame_tick", o_frame_tick, e_tick);
    endtask

    task automatic new_txn(int n);
        req[n] = 1'b1;
        wa[n]  = ($urandom_range(99) < 10) ? 11'($urandom_range(2047, 1200)) : 11'($urandom_range(1199, 0));
        wd[n]  = 4'($urandom);
    endtask

    // Requesters follow the handshake, sometimes holding req one stale cycle after the grant.
    task automatic agent();
        for (int n = 0; n < 2; n++) begin
            if (done[n]) begin
                done[n] = 0;
                req[n]  = 1'b0;
            end else if (req[n] && o_gnt[n]) begin
                if ($urandom_range(1) == 1) done[n] = 1;
                else req[n] = 1'b0;
            end else if (req[n] && $urandom_range(99) < 3) req[n] = 1'b0;
            if (!req[n] && !done[n] && $urandom_range(99) < 40) new_txn(n);
        end
    endtask

    task automatic set_pos(int r, int c);
        row = 10'(r);
        col = 10'(c);
        pv  = (c < 640) && (r < 480);
    endtask

    initial begin
        pv = 0; col = 0; row = 0; req = 0;
        wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
        done[0] = 0; done[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", o_gnt, 0);
        check("rst_we", o_ram_we, 0);
        check("rst_err", o_wr_err, 0);
        check("rst_addr", o_ram_addr, 0);
        check("rst_wdata", o_ram_wdata, 0);
        check("rst_dv", o_disp_valid, 0);
        check("rst_tick", o_frame_tick, 0);
        rst = 1'b0;

        set_pos(35, 100);
        step();
        check("disp_addr_86", o_ram_addr, 86);
        check("disp_we0", o_ram_we, 0);
        set_pos(10, 700);
        req[0] = 1'b1; wa[0] = 11'd5; wd[0] = 4'd3;
        step();
        check("dv_delay2", o_disp_valid, 1);
        check("single_gnt", o_gnt, 2'b01);
        check("single_we", o_ram_we, 1);
        check("single_addr", o_ram_addr, 5);
        check("single_wdata", o_ram_wdata, 3);
        step();
        check("masked_gnt", o_gnt, 0);
        check("masked_we", o_ram_we, 0);
        req = 0;
        step();

        req = 2'b11; wa[0] = 11'd100; wd[0] = 4'd1; wa[1] = 11'd200; wd[1] = 4'd2;
        for (int c = 640; c < 800; c++) begin set_pos(10, c); step(); end
        for (int c = 0; c < 40; c++) begin set_pos(11, c); step(); end
        req = 0;
        set_pos(11, 700);
        step();

        req[1] = 1'b1; wa[1] = 11'd1200; wd[1] = 4'd7;
        step();
        check("oob_gnt", o_gnt, 2'b10);
        check("oob_err", o_wr_err, 1);
        check("oob_we", o_ram_we, 0);
        req = 0;
        step();

        tick_cnt = 0;
        for (int r = 478; r < 482; r++)
            for (int c = 0; c < 800; c++) begin
                set_pos(r, c);
                agent();
                step();
                if (o_frame_tick) tick_cnt++;
            end
        check("tick_count", tick_cnt, 1);

        for (int i = 0, r = 8, c = 600; i < 6000; i++) begin
            set_pos(r, c);
            agent();
            step();
            c = (c == 799) ? 0 : c + 1;
            if (c == 0) r = (r == 520) ? 0 : r + 1;
        end

        req = 0; done[0] = 0; done[1] = 0;
        set_pos(10, 100);
        step();
        step();
        set_pos(10, 700);
        req[0] = 1'b1; wa[0] = 11'd9; wd[0] = 4'd2;
        step();
        check("pre_rst_we", o_ram_we, 1);
        #2 rst = 1'b1;
        #1;
        check("async_we", o_ram_we, 0);
        check("async_gnt", o_gnt, 0);
        check("async_dv", o_disp_valid, 0);
        m_prio = 0; m_prev = -1; m_pv_prev = 0; m_addr = 0; m_wdata = 0;
        req = 2'b11; wa[0] = 11'd11; wd[0] = 4'd4; wa[1] = 11'd22; wd[1] = 4'd8;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("post_rst_gnt0", o_gnt, 2'b01);
        req = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_tilemap_arbiter.md
# vga_tilemap_arbiter

Owns the single-port tile-map RAM (40×30 tiles of 16×16 px) that sits behind the VGA timing generator. Feeds display read addresses from the sync counters during active video, and shares the free blanking cycles between two write requesters (0 = maze loader, 1 = game logic) with a round-robin req/gnt handshake. Also emits a start-of-vertical-blank tick that schedules game-state updates.

## Interface
Parameters:
- TILE_SHIFT, 4: log2 of tile edge in pixels
- MAP_COLS, 40: tiles per row
- MAP_ROWS, 30: tile rows
- ADDR_W, 11: tile-map address width
- DATA_W, 4: tile code width
- HPIXELS, 640: active columns
- VLINES, 480: active lines

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- i_pix_valid  in  1  active-video flag from timing generator
- i_col  in  10  current column (0..799)
- i_row  in  10  current line (0..520)
- i_req  in  2  write request per requester
- i_wr_addr  in  2×ADDR_W  per-requester write address
- i_wr_data  in  2×DATA_W  per-requester write data
- o_gnt  out  2  one-cycle grant per requester
- o_wr_err  out  1  one-cycle pulse: granted write had address ≥ MAP_COLS*MAP_ROWS
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_we  out  1  RAM write enable
- o_ram_wdata  out  DATA_W  RAM write data
- o_disp_valid  out  1  RAM read data is a valid display tile
- o_frame_tick  out  1  one-cycle pulse at start of vertical blank

## Operation
- All outputs registered; reset value 0 for every output; round-robin pointer resets to requester 0.
- Mode per cycle from current inputs: DISP when i_pix_valid=1, else FREE.
- DISP: o_ram_addr ← (i_row>>TILE_SHIFT)*MAP_COLS + (i_col>>TILE_SHIFT), computed as (r<<5)+(r<<3)+c in ADDR_W bits (max 1199, no overflow); o_ram_we ← 0; no grant. Pending requests held off.
- FREE, no eligible request: o_ram_we ← 0, o_ram_addr holds last value.
- FREE, eligible request: arbiter picks one requester; o_ram_we ← 1, o_ram_addr/o_ram_wdata ← that requester's address/data, o_gnt[n] ← 1, pointer ← other requester.
- Round robin: both requesting → the one not granted last wins; single requester wins regardless of pointer.
- Eligibility: requester granted in the previous cycle is masked for one cycle (its req is still high while it observes gnt). Other requester may be granted in that cycle.
- Requester protocol: hold req, addr, data stable until o_gnt seen high; deassert or present new transaction the cycle after. Removing req before grant is legal (request withdrawn, nothing written).
- Out-of-range address: grant still issued, o_ram_we forced 0, o_wr_err pulses with the grant.
- o_frame_tick ← 1 when i_row==VLINES and i_col==0; else 0.

## Timing
- o_ram_addr/we/wdata/gnt valid one cycle after the sampled inputs.
- o_disp_valid = i_pix_valid delayed 2 cycles (1 address register + 1 synchronous RAM read); downstream colour logic delays sync outputs by the same 2 cycles.
- Throughput: one write per FREE cycle; a single requester streams at most one write every 2 cycles (mask rule); both requesters together saturate every FREE cycle.
- FREE→DISP boundary: a request pending in the last blank cycle is granted; a request first seen in a DISP cycle waits for the next FREE cycle (≤ 640 cycles within a line).
- Reset asserted mid-write: o_ram_we and o_gnt clear immediately (asynchronous); requester sees no grant and must re-issue.

## Structure
- Package vga_pkg: HPIXELS, VLINES, TILE_SHIFT, MAP_COLS, MAP_ROWS, ADDR_W, DATA_W, tile_code_t typedef.
- Sub-module rr_arbiter2: 2-way round-robin with one-cycle post-grant mask; inputs req, enable (FREE); outputs one-hot grant; owns the pointer.

## Test plan
- Row 35, col 100, i_pix_valid=1 → next cycle o_ram_addr=86 (2*40+6), o_ram_we=0; o_disp_valid high 2 cycles after i_pix_valid.
- Req0 only, addr 5, data 3, held during col 700 of row 10 → o_gnt=01, o_ram_we=1, o_ram_addr=5, o_ram_wdata=3 next cycle; no second grant the following cycle.
- Both requests held continuously through blanking → grants alternate 01,10,01,…; one write every FREE cycle, none while i_pix_valid=1.
- Req1 with addr 1200 in blanking → o_gnt=10, o_wr_err=1, o_ram_we=0.
- Full 800×521 frame → exactly one o_frame_tick, at row 480 col 0 (+1 cycle).
- Assert rst during a write cycle → o_ram_we, o_gnt, o_disp_valid 0 immediately; after release first dual-request grant goes to requester 0.
